// File: rtl/eth_tx_sched_if.sv
// Signal bundle between the Ethernet transmit scheduler and its surroundings:
// receiver results, UDP sender handshake and transmitter control.
interface eth_tx_sched_if;
   logic [1:0]  i_pkt_type;
   logic [47:0] i_SHA;
   logic [31:0] i_SPA;
   logic [31:0] i_TPA;
   logic [31:0] i_self_ip;
   logic        i_udp_req;
   logic        o_udp_gnt;
   logic        i_tx_done;
   logic        o_tx_start;
   logic [1:0]  o_tx_sel;
   logic [47:0] o_arp_tha;
   logic [31:0] o_arp_tpa;
   logic [7:0]  o_arp_drop_cnt;
   logic        o_tx_timeout;
   logic        o_busy;

   modport master (
      output i_pkt_type, i_SHA, i_SPA, i_TPA, i_self_ip, i_udp_req, i_tx_done,
      input  o_udp_gnt, o_tx_start, o_tx_sel, o_arp_tha, o_arp_tpa,
             o_arp_drop_cnt, o_tx_timeout, o_busy
   );

   modport slave (
      input  i_pkt_type, i_SHA, i_SPA, i_TPA, i_self_ip, i_udp_req, i_tx_done,
      output o_udp_gnt, o_tx_start, o_tx_sel, o_arp_tha, o_arp_tpa,
             o_arp_drop_cnt, o_tx_timeout, o_busy
   );
endinterface

// File: rtl/eth_tx_sched.sv
// Shares one Ethernet transmitter between queued ARP replies and a UDP sender,
// with round-robin arbitration, inter-frame gap and a transmit watchdog.
module eth_tx_sched #(
   parameter int ARP_DEPTH  = 2,
   parameter int IFG_CYCLES = 12,
   parameter int TX_TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          rst,
   eth_tx_sched_if.slave bus
);
   localparam int AW = $clog2(ARP_DEPTH);
   localparam int WW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
   localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [WW-1:0] WD_LAST  = WW'(TX_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT_ARP, WAIT_UDP, GAP} state_t;

   state_t        state, state_nx;
   logic [79:0]   mem [ARP_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [79:0]   head;
   logic          empty, full, rx_arp, push, drop, pop;
   logic          start_q, start_nx, gnt_q, gnt_nx, tmo_q, tmo_nx;
   logic          last_udp, last_udp_nx;
   logic [1:0]    sel_q, sel_nx;
   logic [47:0]   tha_q;
   logic [31:0]   tpa_q;
   logic [7:0]    drop_cnt;
   logic [WW-1:0] wd_cnt, wd_nx;
   logic [GW-1:0] gap_cnt, gap_nx;

   assign rx_arp = (bus.i_pkt_type == 2'd1) && (bus.i_TPA == bus.i_self_ip);
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop on the same edge frees the slot, so a full queue still accepts.
   assign push   = rx_arp && (!full || pop);
   assign drop   = rx_arp && full && !pop;
   assign head   = mem[rd_ptr[AW-1:0]];

   always_comb begin
      state_nx    = state;
      start_nx    = 1'b0;
      sel_nx      = sel_q;
      gnt_nx      = gnt_q;
      tmo_nx      = 1'b0;
      last_udp_nx = last_udp;
      pop         = 1'b0;
      wd_nx       = wd_cnt;
      gap_nx      = gap_cnt;
      unique case (state)
         IDLE: begin
            if (!empty && (!bus.i_udp_req || last_udp)) begin
               state_nx = WAIT_ARP;
               start_nx = 1'b1;
               sel_nx   = 2'd1;
               pop      = 1'b1;
               wd_nx    = '0;
            end else if (bus.i_udp_req) begin
               state_nx = WAIT_UDP;
               start_nx = 1'b1;
               sel_nx   = 2'd2;
               gnt_nx   = 1'b1;
               wd_nx    = '0;
            end
         end
         WAIT_ARP, WAIT_UDP: begin
            wd_nx = wd_cnt + 1'b1;
            // Watchdog expiry takes the same exit as a real done.
            if (bus.i_tx_done || wd_cnt == WD_LAST) begin
               tmo_nx      = !bus.i_tx_done;
               last_udp_nx = (state == WAIT_UDP);
               gnt_nx      = 1'b0;
               sel_nx      = 2'd0;
               gap_nx      = '0;
               state_nx    = (IFG_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_nx = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         start_q  <= 1'b0;
         gnt_q    <= 1'b0;
         tmo_q    <= 1'b0;
         sel_q    <= 2'd0;
         tha_q    <= '0;
         tpa_q    <= '0;
         drop_cnt <= '0;
         last_udp <= 1'b1;
         wd_cnt   <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nx;
         start_q  <= start_nx;
         gnt_q    <= gnt_nx;
         tmo_q    <= tmo_nx;
         sel_q    <= sel_nx;
         last_udp <= last_udp_nx;
         wd_cnt   <= wd_nx;
         gap_cnt  <= gap_nx;
         if (pop) begin
            tha_q  <= head[79:32];
            tpa_q  <= head[31:0];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {bus.i_SHA, bus.i_SPA};
   end

   assign bus.o_tx_start     = start_q;
   assign bus.o_tx_sel       = sel_q;
   assign bus.o_udp_gnt      = gnt_q;
   assign bus.o_arp_tha      = tha_q;
   assign bus.o_arp_tpa      = tpa_q;
   assign bus.o_arp_drop_cnt = drop_cnt;
   assign bus.o_tx_timeout   = tmo_q;
   assign bus.o_busy         = (state != IDLE);
endmodule

// File: tb/tb_eth_tx_sched.sv
// Randomized bench for eth_tx_sched: a frame-level timing model predicts grants,
// per-cycle outputs and drop counts; a negedge monitor checks the DUT against it.
module tb_eth_tx_sched;
   localparam int DEPTH = 2;
   localparam int IFG   = 12;
   localparam int TMO   = 16;
   localparam logic [31:0] SELF = 32'hC0A80001;

   typedef struct packed {
      logic [1:0]  sel;
      logic        gnt;
      logic        busy;
      logic        tmo;
      logic [7:0]  drops;
      logic [47:0] tha;
      logic [31:0] tpa;
   } exp_t;

   typedef struct packed {
      int          cyc;
      logic [1:0]  sel;
      logic [47:0] tha;
      logic [31:0] tpa;
   } start_t;

   logic clk, rst;
   eth_tx_sched_if ifc();

   eth_tx_sched #(.ARP_DEPTH(DEPTH), .IFG_CYCLES(IFG), .TX_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .bus(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     vectors = 0, errors = 0, cyc = 0;
   exp_t   exp_a [int];
   start_t sb [$];

   // Reference model: a frame occupies the link from m_start until done or
   // timeout; arbitration becomes possible again IFG cycles after that.
   logic [79:0] m_q [$];
   int          m_src = 0, m_start = 0, m_free_at = 0, m_dly = 0, m_drops = 0;
   bit          m_last_udp = 1'b1;
   logic [47:0] m_tha = '0;
   logic [31:0] m_tpa = '0;
   int          dly_force = -1;
   bit          spur_en = 1'b0;

   task automatic model_step();
      exp_t        e;
      logic [79:0] h;
      bit          arp, udp;
      e = '0;
      if (rst) begin
         m_q.delete();
         m_src = 0; m_free_at = 0; m_last_udp = 1'b1; m_drops = 0;
         m_tha = '0; m_tpa = '0;
      end else begin
         if (m_src != 0 && m_start <= cyc) begin
            if (ifc.i_tx_done || (cyc - m_start) == TMO - 1) begin
               e.tmo      = !ifc.i_tx_done;
               m_last_udp = (m_src == 2);
               m_src      = 0;
               m_free_at  = cyc + 1 + IFG;
            end
         end else if (m_src == 0 && cyc >= m_free_at) begin
            arp = (m_q.size() != 0);
            udp = ifc.i_udp_req;
            if (arp && (!udp || m_last_udp)) begin
               h = m_q.pop_front();
               m_tha = h[79:32]; m_tpa = h[31:0];
               m_src = 1;
               sb.push_back('{cyc + 1, 2'd1, m_tha, m_tpa});
            end else if (udp) begin
               m_src = 2;
               sb.push_back('{cyc + 1, 2'd2, 48'd0, 32'd0});
            end
            if (m_src != 0) begin
               m_start = cyc + 1;
               if (dly_force >= 0) m_dly = dly_force;
               else m_dly = ($urandom_range(7) == 0) ? 1000 : int'($urandom_range(12));
            end
         end
         if (ifc.i_pkt_type == 2'd1 && ifc.i_TPA == ifc.i_self_ip) begin
            if (m_q.size() < DEPTH) m_q.push_back({ifc.i_SHA, ifc.i_SPA});
            else if (m_drops < 255) m_drops++;
         end
      end
      e.sel   = 2'(m_src);
      e.gnt   = (m_src == 2);
      e.busy  = (m_src != 0) || (cyc + 1 < m_free_at);
      e.drops = 8'(m_drops);
      e.tha   = m_tha;
      e.tpa   = m_tpa;
      exp_a[cyc + 1] = e;
   endtask

   task automatic run_cycle();
      if (!rst && m_src != 0 && m_start <= cyc && (cyc - m_start) >= m_dly)
         ifc.i_tx_done = 1'b1;
      else if (spur_en && m_src == 0 && $urandom_range(9) == 0)
         ifc.i_tx_done = 1'b1;
      model_step();
      @(posedge clk);
      cyc++;
      #1;
      ifc.i_pkt_type = 2'd0;
      ifc.i_tx_done  = 1'b0;
      rst            = 1'b0;
   endtask

   task automatic set_pkt(input logic [1:0] t, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa);
      ifc.i_pkt_type = t; ifc.i_SHA = sha; ifc.i_SPA = spa; ifc.i_TPA = tpa;
   endtask

   task automatic wait_quiet(input int bound);
      int n = 0;
      while (!(m_src == 0 && cyc >= m_free_at && m_q.size() == 0 && !ifc.i_udp_req)
             && n < bound) begin
         run_cycle();
         n++;
      end
      if (n >= bound) begin
         errors++;
         $display("FAIL wait_quiet: still busy after %0d cycles, required idle", bound);
      end
   endtask

   task automatic wait_frame(input int src, input int bound);
      int n = 0;
      while (m_src != src && n < bound) begin
         run_cycle();
         n++;
      end
      if (n >= bound) begin
         errors++;
         $display("FAIL wait_frame: no src %0d grant within %0d cycles", src, bound);
      end
   endtask

   always @(negedge clk) begin
      exp_t   a;
      start_t s;
      if (exp_a.exists(cyc)) begin
         a = '{ifc.o_tx_sel, ifc.o_udp_gnt, ifc.o_busy, ifc.o_tx_timeout,
               ifc.o_arp_drop_cnt, ifc.o_arp_tha, ifc.o_arp_tpa};
         vectors++;
         if (a !== exp_a[cyc]) begin
            errors++;
            $display("FAIL outputs cycle %0d: got sel/gnt/busy/tmo/drop/tha/tpa=%h, required %h",
                     cyc, a, exp_a[cyc]);
         end
         exp_a.delete(cyc);
      end
      if (ifc.o_tx_start === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL start cycle %0d: unexpected o_tx_start sel=%0d, required none",
                     cyc, ifc.o_tx_sel);
         end else begin
            s = sb.pop_front();
            if (s.cyc != cyc || s.sel !== ifc.o_tx_sel ||
                (s.sel == 2'd1 && (s.tha !== ifc.o_arp_tha || s.tpa !== ifc.o_arp_tpa))) begin
               errors++;
               $display("FAIL start: got cyc=%0d sel=%0d tha=%h tpa=%h, required cyc=%0d sel=%0d tha=%h tpa=%h",
                        cyc, ifc.o_tx_sel, ifc.o_arp_tha, ifc.o_arp_tpa,
                        s.cyc, s.sel, s.tha, s.tpa);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      ifc.i_self_ip = SELF;
      ifc.i_udp_req = 1'b0;
      ifc.i_tx_done = 1'b0;
      set_pkt(2'd0, '0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         rst = 1'b1;
         run_cycle();
      end

      // single ARP request, start expected two cycles later, then full gap
      dly_force = 3;
      set_pkt(2'd1, 48'h0011_2233_4455, 32'hC0A80002, SELF);
      run_cycle();
      wait_quiet(100);

      // mismatched target IP and an ARP response are ignored
      set_pkt(2'd1, 48'h0A0B_0C0D_0E0F, 32'hC0A80003, 32'hC0A80009);
      run_cycle();
      set_pkt(2'd2, 48'h0A0B_0C0D_0E0F, 32'hC0A80003, SELF);
      run_cycle();
      for (int i = 0; i < 5; i++) run_cycle();

      // three requests while a UDP frame holds the link: one is dropped
      dly_force = 8;
      ifc.i_udp_req = 1'b1;
      wait_frame(2, 50);
      ifc.i_udp_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_pkt(2'd1, 48'h1000_0000_0000 + 48'(i), 32'hC0A81000 + 32'(i), SELF);
         run_cycle();
      end
      dly_force = 2;
      wait_quiet(200);

      // watchdog: UDP frame with no done
      dly_force = 1000;
      ifc.i_udp_req = 1'b1;
      wait_frame(2, 50);
      ifc.i_udp_req = 1'b0;
      wait_quiet(100);

      // round robin with both sources continuously ready
      dly_force = 1;
      set_pkt(2'd1, 48'h2000_0000_0001, 32'hC0A82001, SELF);
      run_cycle();
      set_pkt(2'd1, 48'h2000_0000_0002, 32'hC0A82002, SELF);
      ifc.i_udp_req = 1'b1;
      run_cycle();
      for (int i = 0; i < 80; i++) run_cycle();
      ifc.i_udp_req = 1'b0;
      wait_quiet(200);

      // reset in WAIT_UDP with two queued requests
      dly_force = 10;
      ifc.i_udp_req = 1'b1;
      wait_frame(2, 50);
      ifc.i_udp_req = 1'b0;
      set_pkt(2'd1, 48'h3000_0000_0001, 32'hC0A83001, SELF);
      run_cycle();
      set_pkt(2'd1, 48'h3000_0000_0002, 32'hC0A83002, SELF);
      run_cycle();
      rst = 1'b1;
      run_cycle();
      for (int i = 0; i < 40; i++) run_cycle();

      // randomized traffic
      dly_force = -1;
      spur_en   = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) ifc.i_udp_req = ~ifc.i_udp_req;
         if ($urandom_range(9) < 3)
            set_pkt(2'($urandom_range(3)), 48'({$urandom(), $urandom()}), $urandom(),
                    ($urandom_range(9) < 7) ? SELF : $urandom());
         run_cycle();
      end
      spur_en = 1'b0;
      ifc.i_udp_req = 1'b0;
      wait_quiet(2000);
      run_cycle();

      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d expected starts never seen, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
